// File: rtl/vz_line_scaler_if.sv
// Source-pixel write bus of the line scaler.
//   src_valid : write strobe for one source pixel
//   src_x     : source pixel column (0..SRC_WIDTH-1 are accepted)
//   src_y     : source line number (0..SRC_HEIGHT-1 are accepted)
//   src_color : 6-bit colour index (RRGGBB, 2 bits per channel)
// master = pixel producer, slave = vz_line_scaler.
interface vz_line_scaler_if;
    logic       src_valid;
    logic [8:0] src_x;
    logic [7:0] src_y;
    logic [5:0] src_color;

    modport master (output src_valid, output src_x, output src_y, output src_color);
    modport slave  (input  src_valid, input  src_x, input  src_y, input  src_color);
endinterface

// File: rtl/vz_line_scaler.sv
// Integer line-doubling scaler between a source pixel producer and an HDMI
// timing generator. Source lines are written into two ping-pong line buffers
// (bank = line parity) and read back at SCALE = 2**SCALE_SHIFT in both
// directions, placed at (X_OFFSET, Y_OFFSET) on screen, BORDER_RGB elsewhere.
// Ports:
//   I_clk_pixel  : pixel clock (only clock)
//   I_reset      : asynchronous active-high reset
//   src          : source write bus (vz_line_scaler_if.slave)
//   pixX, pixY   : current HDMI coordinate
//   rgb          : 24-bit colour, 2 cycles after pixX/pixY
//   underrun     : sticky flag, set when a displayed line was not (fully) in its bank
//   underrun_clr : clears underrun on the next cycle
module vz_line_scaler #(
    parameter int          X_BW        = 11,
    parameter int          Y_BW        = 10,
    parameter int          SRC_WIDTH   = 256,
    parameter int          SRC_HEIGHT  = 192,
    parameter int          SCALE_SHIFT = 1,
    parameter int          X_OFFSET    = 64,
    parameter int          Y_OFFSET    = 48,
    parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
    input  logic               I_clk_pixel,
    input  logic               I_reset,
    vz_line_scaler_if.slave    src,
    input  logic [X_BW-1:0]    pixX,
    input  logic [Y_BW-1:0]    pixY,
    output logic [23:0]        rgb,
    output logic               underrun,
    input  logic               underrun_clr
);
    localparam int AW = $clog2(SRC_WIDTH);

    localparam logic [8:0]      SRC_W_L  = 9'(SRC_WIDTH);
    localparam logic [8:0]      SRC_H_L  = 9'(SRC_HEIGHT);
    localparam logic [8:0]      LAST_X   = 9'(SRC_WIDTH - 1);
    localparam logic [X_BW-1:0] X_LO     = X_BW'(X_OFFSET);
    localparam logic [X_BW:0]   X_HI     = (X_BW+1)'(X_OFFSET + (SRC_WIDTH << SCALE_SHIFT));
    localparam logic [Y_BW-1:0] Y_LO     = Y_BW'(Y_OFFSET);
    localparam logic [Y_BW:0]   Y_HI     = (Y_BW+1)'(Y_OFFSET + (SRC_HEIGHT << SCALE_SHIFT));

    // 2-bit channel to 8-bit by replication: 0,1,2,3 -> 00,55,AA,FF
    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    function automatic logic [23:0] color_to_rgb(input logic [5:0] c);
        return {expand2(c[5:4]), expand2(c[3:2]), expand2(c[1:0])};
    endfunction

    // ---------------- write side ----------------
    logic          wr_en;
    logic          wr_bank;
    logic          wr_first;
    logic          wr_last;
    logic [AW-1:0] wr_addr;

    // Writes landing on the edge where reset is held are dropped.
    assign wr_en    = src.src_valid && (src.src_x < SRC_W_L) &&
                      ({1'b0, src.src_y} < SRC_H_L) && !I_reset;
    assign wr_bank  = src.src_y[0];
    assign wr_first = (src.src_x == 9'd0);
    assign wr_last  = (src.src_x == LAST_X);
    assign wr_addr  = AW'(src.src_x);

    logic [5:0] bank0 [SRC_WIDTH];
    logic [5:0] bank1 [SRC_WIDTH];
    logic [7:0] tag0;
    logic [7:0] tag1;
    logic [1:0] tag_valid;

    always_ff @(posedge I_clk_pixel) begin
        if (wr_en && !wr_bank) bank0[wr_addr] <= src.src_color;
        if (wr_en &&  wr_bank) bank1[wr_addr] <= src.src_color;
    end

    always_ff @(posedge I_clk_pixel) begin
        if (wr_en && wr_last) begin
            if (wr_bank) tag1 <= src.src_y;
            else         tag0 <= src.src_y;
        end
    end

    // A bank's tag is only trusted once its last pixel is written; starting a
    // new line in the bank withdraws it until that line completes.
    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            tag_valid <= 2'b00;
        end else if (wr_en) begin
            if (wr_last)       tag_valid[wr_bank] <= 1'b1;
            else if (wr_first) tag_valid[wr_bank] <= 1'b0;
        end
    end

    // ---------------- read side ----------------
    logic            in_win;
    logic [X_BW-1:0] x_rel;
    logic [Y_BW-1:0] y_rel;
    logic [AW-1:0]   sx;
    logic [7:0]      sy;

    assign in_win = (pixX >= X_LO) && ({1'b0, pixX} < X_HI) &&
                    (pixY >= Y_LO) && ({1'b0, pixY} < Y_HI);
    assign x_rel  = pixX - X_LO;
    assign y_rel  = pixY - Y_LO;
    assign sx     = AW'(x_rel >> SCALE_SHIFT);
    assign sy     = 8'(y_rel >> SCALE_SHIFT);

    // ---- stage 1: window flag, bank, address, line ----
    logic          vld_p1;
    logic          bank_p1;
    logic [AW-1:0] addr_p1;
    logic [7:0]    line_p1;

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) vld_p1 <= 1'b0;
        else         vld_p1 <= in_win;
    end

    // Coordinates are only captured inside the window; outside, vld_p1 masks them.
    always_ff @(posedge I_clk_pixel) begin
        if (in_win) begin
            bank_p1 <= sy[0];
            addr_p1 <= sx;
            line_p1 <= sy;
        end
    end

    // ---- stage 2: buffer read, colour map, underrun ----
    logic [5:0] rd_color;
    logic       tag_hit;

    // Read is sampled on the same edge as a concurrent write, so it sees old data.
    assign rd_color = bank_p1 ? bank1[addr_p1] : bank0[addr_p1];
    assign tag_hit  = bank_p1 ? (tag_valid[1] && (tag1 == line_p1))
                              : (tag_valid[0] && (tag0 == line_p1));

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            rgb      <= BORDER_RGB;
            underrun <= 1'b0;
        end else begin
            rgb <= vld_p1 ? color_to_rgb(rd_color) : BORDER_RGB;
            // set wins over a simultaneous clear
            if (vld_p1 && !tag_hit) underrun <= 1'b1;
            else if (underrun_clr)  underrun <= 1'b0;
        end
    end
endmodule

// File: doc/vz_line_scaler.md
VZ_LINE_SCALER -- requirements
Module: vz_line_scaler

Interface
REQ-001 SHALL have parameter X_BW, 11, width of pixel X coordinate.
REQ-002 SHALL have parameter Y_BW, 10, width of pixel Y coordinate.
REQ-003 SHALL have parameter SRC_WIDTH, 256, source pixels per line.
REQ-004 SHALL have parameter SRC_HEIGHT, 192, source lines per frame.
REQ-005 SHALL have parameter SCALE_SHIFT, 1, integer scale = 2**SCALE_SHIFT; legal values 0..2.
REQ-006 SHALL have parameters X_OFFSET, 64, and Y_OFFSET, 48, screen position of active window top-left.
REQ-007 SHALL have parameter BORDER_RGB, 24'h000000, colour outside active window.
REQ-008 SHALL have ports: I_clk_pixel input 1, pixel clock, only clock.
REQ-009 SHALL have ports: I_reset input 1, asynchronous, active-high reset.
REQ-010 SHALL have ports: src_valid input 1, source pixel write strobe.
REQ-011 SHALL have ports: src_x input 9, source pixel column; src_y input 8, source line; src_color input 6, colour index.
REQ-012 SHALL have ports: pixX input X_BW and pixY input Y_BW, current HDMI coordinate.
REQ-013 SHALL have ports: rgb output 24, pixel colour to HDMI encoder.
REQ-014 SHALL have ports: underrun output 1, sticky line-not-ready flag; underrun_clr input 1, clears it.

Function
REQ-015 SHALL hold two line-buffer banks, each SRC_WIDTH x 6 bits; bank select = line parity.
REQ-016 SHALL, on src_valid with src_x < SRC_WIDTH and src_y < SRC_HEIGHT, write src_color to bank src_y[0] at address src_x; out-of-range writes ignored.
REQ-017 SHALL keep per-bank tag (8 bits) and tag_valid; writing src_x == SRC_WIDTH-1 sets that bank's tag = src_y, tag_valid = 1.
REQ-018 SHALL invalidate bank tag_valid on first write (src_x == 0) of a new line to that bank.
REQ-019 SHALL define active window: X_OFFSET <= pixX < X_OFFSET + SRC_WIDTH<<SCALE_SHIFT, same for Y with SRC_HEIGHT.
REQ-020 SHALL compute sx = (pixX - X_OFFSET) >> SCALE_SHIFT, sy = (pixY - Y_OFFSET) >> SCALE_SHIFT, evaluated only inside window; no division hardware.
REQ-021 SHALL pipeline reads in 2 stages: stage 1 registers window flag, bank sy[0], address sx, line sy; stage 2 registers rgb.
REQ-022 SHALL give fixed latency of exactly 2 I_clk_pixel cycles from pixX/pixY to rgb, inside and outside window.
REQ-023 SHALL output BORDER_RGB when stage-1 window flag is 0.
REQ-024 SHALL map index c to rgb: R = c[5:4]*85, G = c[3:2]*85, B = c[1:0]*85 (2-bit to 8-bit replication, 3 -> 8'hFF).
REQ-025 SHALL, on a same-cycle write and read of the same bank/address, return the old (pre-write) data.
REQ-026 SHALL set underrun in stage 2 when an active read hits a bank whose tag_valid = 0 or tag != sy; rgb still shows buffer contents.
REQ-027 SHALL clear underrun one cycle after underrun_clr = 1; simultaneous set and clear resolve to set.
REQ-028 SHALL support pixX/pixY wrap (new frame) with no state flush; pipeline behaves identically.

Reset
REQ-029 SHALL, while I_reset = 1, force rgb = BORDER_RGB, underrun = 0, both tag_valid = 0, pipeline window flags = 0.
REQ-030 SHALL not require line-buffer contents to be reset.
REQ-031 SHALL discard writes and reads in flight when reset asserts mid-line; first rgb after release valid 2 cycles after first coordinate.

Verification
REQ-032 Reset: assert I_reset mid-frame -> rgb = 000000, underrun = 0 same cycle; release, feed pixX=0,pixY=0 -> rgb = 000000 at cycle 2.
REQ-033 Mapping: write line 0 x=0 color 6'b110110, x=255 complete; pixX=64,65,pixY=48 -> rgb = FF55AA at cycles 2 and 3 (scale 2 repeats).
REQ-034 Window edge: pixX=63 -> BORDER_RGB; pixX=575 -> last source pixel; pixX=576 -> BORDER_RGB; likewise pixY=47/431/432.
REQ-035 Underrun: read line sy=1 with bank 1 never completed -> underrun = 1 within 2 cycles, stays set; underrun_clr pulse -> 0 next cycle.
REQ-036 Collision: write bank 0 addr 10 new colour same cycle as reading it -> old colour output; next read -> new colour.
REQ-037 Range: src_x=300 or src_y=200 writes -> no buffer or tag change.
